// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the integer ALU: decodes RV32I ALU instructions into a
// 4-bit ALU opcode, resolves forwarded operands and registers them behind a valid/ready handshake.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        exm_wen,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_res,
    input  logic        mwb_wen,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_res,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [3:0]  ex_ALUOp,
    output logic [4:0]  ex_rd,
    output logic        ex_wen,
    output logic        illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OPW  = 4;
    localparam int unsigned SHW  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OPW-1:0]  aluop;
        logic [RW-1:0]   rd;
        logic            wen;
    } issue_t;

    issue_t          dec_c;
    issue_t          iss_q;
    logic            legal_c;
    logic            capture_c;
    logic            valid_q;
    logic            illegal_q;
    logic [XLEN-1:0] rs1_c;
    logic [XLEN-1:0] rs2_c;

    // Only funct7[5] distinguishes ALU operations; the rest is don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Operand bypass: EX/MEM wins over MEM/WB, x0 always reads as zero.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RW-1:0]   addr,
        input logic [XLEN-1:0] rf,
        input logic            e_wen,
        input logic [RW-1:0]   e_rd,
        input logic [XLEN-1:0] e_res,
        input logic            m_wen,
        input logic [RW-1:0]   m_rd,
        input logic [XLEN-1:0] m_res
    );
        logic [XLEN-1:0] v;
        v = rf;
        if (addr == '0)                     v = '0;
        else if (e_wen && (e_rd == addr))   v = e_res;
        else if (m_wen && (m_rd == addr))   v = m_res;
        return v;
    endfunction

    assign id_ready  = !valid_q || ex_ready;
    assign capture_c = id_valid && id_ready;

    // Decode and operand selection for the instruction on the ID side.
    always_comb begin
        rs1_c    = resolve(rs1_addr, rs1_data, exm_wen, exm_rd, exm_res, mwb_wen, mwb_rd, mwb_res);
        rs2_c    = resolve(rs2_addr, rs2_data, exm_wen, exm_rd, exm_res, mwb_wen, mwb_rd, mwb_res);
        dec_c    = '0;
        dec_c.rd = rd_addr;
        legal_c  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_c.aluop = {((funct3 == 3'b000) || (funct3 == 3'b101)) && funct7[5], funct3};
                dec_c.a     = rs1_c;
                dec_c.b     = rs2_c;
            end
            OPC_OP_IMM: begin
                dec_c.aluop = {(funct3 == 3'b101) && funct7[5], funct3};
                dec_c.a     = rs1_c;
                dec_c.b     = imm;
            end
            OPC_LUI: begin
                dec_c.a = '0;
                dec_c.b = imm;
            end
            OPC_AUIPC: begin
                dec_c.a = pc;
                dec_c.b = imm;
            end
            default: legal_c = 1'b0;
        endcase
        // Shift amount is only the low five bits for both register and immediate forms.
        if ((dec_c.aluop[2:0] == 3'b001) || (dec_c.aluop[2:0] == 3'b101)) begin
            dec_c.b = {{(XLEN-SHW){1'b0}}, dec_c.b[SHW-1:0]};
        end
        dec_c.wen = legal_c && (rd_addr != '0);
    end

    // Issue register: reset > flush > capture > drain; everything holds during a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            iss_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            iss_q.wen <= 1'b0;
        end else if (capture_c) begin
            valid_q   <= legal_c;
            illegal_q <= !legal_c;
            iss_q     <= dec_c;
        end else begin
            illegal_q <= 1'b0;
            if (ex_ready) begin
                valid_q   <= 1'b0;
                iss_q.wen <= 1'b0;
            end
        end
    end

    assign ex_valid = valid_q;
    assign ex_A     = iss_q.a;
    assign ex_B     = iss_q.b;
    assign ex_ALUOp = iss_q.aluop;
    assign ex_rd    = iss_q.rd;
    assign ex_wen   = iss_q.wen;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding priority, shifts, LUI/AUIPC,
// stall hold, flush and illegal-opcode handling against hand-computed values.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        exm_wen, mwb_wen;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_res, mwb_res;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_A, ex_B;
    logic [3:0]  ex_ALUOp;
    logic [4:0]  ex_rd;
    logic        ex_wen;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .pc(pc), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_res(exm_res),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_res(mwb_res),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_A(ex_A), .ex_B(ex_B), .ex_ALUOp(ex_ALUOp), .ex_rd(ex_rd),
        .ex_wen(ex_wen), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] im);
        opcode = opc; funct3 = f3; funct7 = f7;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd; imm = im;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] op, input logic [4:0] rd,
                             input logic wen);
        check({tag, ".valid"}, 32'(ex_valid), 32'(v));
        check({tag, ".A"},     ex_A, a);
        check({tag, ".B"},     ex_B, b);
        check({tag, ".op"},    32'(ex_ALUOp), 32'(op));
        check({tag, ".rd"},    32'(ex_rd), 32'(rd));
        check({tag, ".wen"},   32'(ex_wen), 32'(wen));
    endtask

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] LOAD  = 7'b0000011;

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        pc = '0; rs1_data = '0; rs2_data = '0;
        exm_wen = 1'b0; exm_rd = '0; exm_res = '0;
        mwb_wen = 1'b0; mwb_rd = '0; mwb_res = '0;
        instr(OP, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd3, 32'h0);
        rs1_data = 32'd7; rs2_data = 32'd3;

        // reset holds everything at zero even with a valid instruction presented
        id_valid = 1'b1;
        step(); step();
        check_out("reset", 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);
        check("reset.illegal", 32'(illegal), 32'h0);
        check("reset.id_ready", 32'(id_ready), 32'h1);

        // OP sub from register file
        rst_n = 1'b1;
        step();
        check_out("sub", 1'b1, 32'd7, 32'd3, 4'b1000, 5'd3, 1'b1);
        check("sub.illegal", 32'(illegal), 32'h0);

        // forwarding priority on rs1
        instr(OP, 3'b000, 7'b0000000, 5'd5, 5'd2, 5'd4, 32'h0);
        rs1_data = 32'hCC;
        exm_wen = 1'b1; exm_rd = 5'd5; exm_res = 32'hAA;
        mwb_wen = 1'b1; mwb_rd = 5'd5; mwb_res = 32'hBB;
        step();
        check_out("fwd_exm", 1'b1, 32'hAA, 32'd3, 4'b0000, 5'd4, 1'b1);
        exm_wen = 1'b0;
        step();
        check("fwd_mwb.A", ex_A, 32'hBB);

        // x0 never forwards
        exm_wen = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        instr(OP, 3'b000, 7'b0000000, 5'd0, 5'd2, 5'd4, 32'h0);
        step();
        check("fwd_x0.A", ex_A, 32'h0);

        // rs2 forwarding; funct7[5] ignored for AND
        exm_rd = 5'd5; mwb_rd = 5'd5;
        instr(OP, 3'b111, 7'b0100000, 5'd0, 5'd5, 5'd9, 32'h0);
        step();
        check_out("and_fwd2", 1'b1, 32'h0, 32'hAA, 4'b0111, 5'd9, 1'b1);

        // srai: shift amount masked, arithmetic bit kept
        exm_wen = 1'b0; mwb_wen = 1'b0;
        rs1_data = 32'h8000_0000;
        instr(OPIMM, 3'b101, 7'b0100000, 5'd1, 5'd0, 5'd6, 32'h405);
        step();
        check_out("srai", 1'b1, 32'h8000_0000, 32'h5, 4'b1101, 5'd6, 1'b1);

        // sll register form: B masked, funct7[5] forced off
        rs2_data = 32'hFFFF_FF23;
        instr(OP, 3'b001, 7'b0100000, 5'd1, 5'd2, 5'd6, 32'h0);
        step();
        check_out("sll", 1'b1, 32'h8000_0000, 32'h3, 4'b0001, 5'd6, 1'b1);

        // addi with imm[10] set stays add and keeps full B
        instr(OPIMM, 3'b000, 7'b0100000, 5'd1, 5'd0, 5'd8, 32'h400);
        step();
        check_out("addi", 1'b1, 32'h8000_0000, 32'h400, 4'b0000, 5'd8, 1'b1);

        // LUI ignores rs1 forwarding; rd = 0 gives wen = 0
        exm_wen = 1'b1; exm_rd = 5'd5;
        instr(LUI, 3'b000, 7'b0000000, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        step();
        check_out("lui", 1'b1, 32'h0, 32'h1234_5000, 4'b0000, 5'd0, 1'b0);

        // AUIPC
        exm_wen = 1'b0; pc = 32'h100;
        instr(AUIPC, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd10, 32'h1000);
        step();
        check_out("auipc", 1'b1, 32'h100, 32'h1000, 4'b0000, 5'd10, 1'b1);

        // stall: X captured, then held for 3 cycles while Y waits and forwarding changes
        exm_wen = 1'b1; exm_rd = 5'd11; exm_res = 32'h11;
        rs2_data = 32'h22;
        instr(OP, 3'b100, 7'b0000000, 5'd11, 5'd2, 5'd7, 32'h0);
        step();
        check_out("stall_x", 1'b1, 32'h11, 32'h22, 4'b0100, 5'd7, 1'b1);
        ex_ready = 1'b0;
        instr(OP, 3'b110, 7'b0000000, 5'd11, 5'd2, 5'd12, 32'h0);
        for (int i = 0; i < 3; i++) begin
            exm_res = 32'h99 + 32'(i);
            #1;
            check("stall.id_ready", 32'(id_ready), 32'h0);
            step();
            check_out("stall_hold", 1'b1, 32'h11, 32'h22, 4'b0100, 5'd7, 1'b1);
        end
        ex_ready = 1'b1;
        #1;
        check("release.id_ready", 32'(id_ready), 32'h1);
        step();
        check_out("stall_y", 1'b1, 32'h9B, 32'h22, 4'b0110, 5'd12, 1'b1);

        // drain: no capture with ex_ready high
        id_valid = 1'b0;
        step();
        check("drain.valid", 32'(ex_valid), 32'h0);
        check("drain.wen", 32'(ex_wen), 32'h0);

        // flush beats simultaneous capture of an illegal opcode
        exm_wen = 1'b0;
        id_valid = 1'b1; flush = 1'b1;
        instr(LOAD, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd3, 32'h0);
        #1;
        check("flush.id_ready", 32'(id_ready), 32'h1);
        step();
        check("flush.valid", 32'(ex_valid), 32'h0);
        check("flush.illegal", 32'(illegal), 32'h0);
        check("flush.wen", 32'(ex_wen), 32'h0);

        // flush during a stall drops the held instruction; id_ready unaffected
        flush = 1'b0;
        instr(OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'h0);
        step();
        check("pre_flush.valid", 32'(ex_valid), 32'h1);
        ex_ready = 1'b0; flush = 1'b1;
        #1;
        check("stall_flush.id_ready", 32'(id_ready), 32'h0);
        step();
        check("stall_flush.valid", 32'(ex_valid), 32'h0);
        check("stall_flush.wen", 32'(ex_wen), 32'h0);
        flush = 1'b0; ex_ready = 1'b1;

        // illegal opcode: bubble plus a single-cycle pulse
        instr(LOAD, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd3, 32'h0);
        step();
        check("illegal.valid", 32'(ex_valid), 32'h0);
        check("illegal.pulse", 32'(illegal), 32'h1);
        check("illegal.wen", 32'(ex_wen), 32'h0);
        id_valid = 1'b0;
        step();
        check("illegal.clear", 32'(illegal), 32'h0);

        // reset mid-stall drops the held instruction
        id_valid = 1'b1;
        instr(OP, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd3, 32'h0);
        step();
        check("pre_rst.valid", 32'(ex_valid), 32'h1);
        ex_ready = 1'b0; rst_n = 1'b0;
        step();
        check_out("rst_stall", 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
